// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bundles the write strobe, show-ahead read port and status signals of the
// UART receive FIFO.
//   slave  : the FIFO itself (takes wr_*, rd_ready and ovr_clr; drives data/status)
//   master : the surrounding logic (UART receiver + controller)
// Parameter DEPTH sets the width of level ($clog2(DEPTH)+1 bits).
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]    wr_data;
    logic          wr_stb;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          overrun;
    logic          ovr_clr;
    logic          timeout;

    modport slave (
        input  wr_data, wr_stb, rd_ready, ovr_clr,
        output rd_data, rd_valid, level, full, overrun, timeout
    );

    modport master (
        output wr_data, wr_stb, rd_ready, ovr_clr,
        input  rd_data, rd_valid, level, full, overrun, timeout
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive byte buffer behind the UART receiver. Each wr_stb pulse stores
// wr_data in a DEPTH-entry circular FIFO; bytes leave through a show-ahead
// valid/ready port. Reports fill level, full and a sticky overrun flag.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : uart_rx_fifo_if.slave
//            wr_data/wr_stb   byte + single-cycle strobe from the receiver
//            rd_data/rd_valid/rd_ready  show-ahead read port
//            level/full       fill status
//            overrun/ovr_clr  sticky drop flag and its clear
//            timeout          idle-timeout flag
//
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the idle counter
// behind `timeout`. Without it, timeout is constant 0.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int TIMEOUT_CYC = 104160
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 2");
    end

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] level_int;
    logic          full_int;
    logic          rd_xfer;
    logic          wr_acc;
    logic          drop;
    logic          overrun_reg;

    // Pointers carry an extra wrap bit, so the difference is the fill level
    // even when the addresses coincide (empty vs. full).
    assign level_int = wr_ptr_reg - rd_ptr_reg;
    assign full_int  = (level_int == PW'(DEPTH));
    assign rd_xfer   = (level_int != '0) && bus.rd_ready;
    // A read in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted when paired with a read.
    assign wr_acc    = bus.wr_stb && (!full_int || rd_xfer);
    assign drop      = bus.wr_stb && full_int && !rd_xfer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_acc)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_xfer)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage is not reset; contents behind the read pointer are don't-care.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr_reg[AW-1:0]] <= bus.wr_data;
    end

    // A drop in the same cycle as ovr_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_reg <= 1'b0;
        else if (drop)
            overrun_reg <= 1'b1;
        else if (bus.ovr_clr)
            overrun_reg <= 1'b0;
    end

    assign bus.rd_data  = mem[rd_ptr_reg[AW-1:0]];
    assign bus.rd_valid = (level_int != '0);
    assign bus.level    = level_int;
    assign bus.full     = full_int;
    assign bus.overrun  = overrun_reg;

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] idle_cnt_reg;
    logic          timeout_reg;

    // Counts edges spent holding data with no traffic. The flag sets on the
    // edge where the count reaches TIMEOUT_CYC, after which counting stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (wr_acc || rd_xfer || level_int == '0) begin
            idle_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (!timeout_reg) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
            if (idle_cnt_reg == CW'(TIMEOUT_CYC - 1))
                timeout_reg <= 1'b1;
        end
    end

    assign bus.timeout = timeout_reg;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (DEPTH=16, TIMEOUT_CYC=8). Stimulus is driven
// cycle by cycle; expectations come from a queue-based model of the FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int TC    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: byte queue, sticky drop flag, idle-edge count.
    logic [7:0] q[$];
    bit         m_ovr;
    int         m_idle;
    logic [7:0] popped;

    function automatic bit exp_timeout();
`ifdef UART_RX_FIFO_TIMEOUT_EN
        return (q.size() > 0) && (m_idle >= TC);
`else
        return 1'b0;
`endif
    endfunction

    // One clock: apply inputs, take the edge, advance the model.
    task automatic cyc(input bit ws, input logic [7:0] wd, input bit rr, input bit clr);
        bit rx, wa, dr, was_empty;
        bus.wr_stb   = ws;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        bus.ovr_clr  = clr;
        was_empty = (q.size() == 0);
        rx = !was_empty && rr;
        wa = ws && (q.size() < DEPTH || rx);
        dr = ws && (q.size() == DEPTH) && !rx;
        @(posedge clk);
        #1;
        if (rx) popped = q.pop_front();
        if (wa) q.push_back(wd);
        if (dr) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        if (rx || wa || was_empty) m_idle = 0;
        else if (m_idle < 1000) m_idle++;
        if (rx || wa || dr)
            $display("[TB] t=%0t wr=%0d(%02h) rd=%0d(%02h) drop=%0d level=%0d",
                     $time, wa, wd, rx, popped, dr, q.size());
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr  = 1'b0;
        m_idle = 0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        cyc(0, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        // Reset asserted mid-cycle must clear state without an edge.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (bus.level !== LW'(0)) begin n_fail++; $display("FAIL reset_level got %0d want 0", bus.level); end
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus.full); end
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", bus.timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        cyc(1, 8'h55, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        n_tests++; if (bus.level !== LW'(2)) begin n_fail++; $display("FAIL basic_level got %0d want 2", bus.level); end
        n_tests++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rd_valid got %b want 1", bus.rd_valid); end
        n_tests++; if (bus.rd_data !== 8'h55) begin n_fail++; $display("FAIL basic_head got %02h want 55", bus.rd_data); end
        cyc(0, 8'h00, 1, 0);
        n_tests++; if (bus.rd_data !== 8'hA3) begin n_fail++; $display("FAIL basic_second got %02h want a3", bus.rd_data); end
        n_tests++; if (bus.level !== LW'(1)) begin n_fail++; $display("FAIL basic_level1 got %0d want 1", bus.level); end
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0); // rd_ready while empty: ignored
        n_tests++; if (bus.level !== LW'(0)) begin n_fail++; $display("FAIL basic_empty got %0d want 0", bus.level); end
    endtask

    task automatic test_fill_overrun();
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
        n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", bus.full); end
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL fill_ovr got %b want 0", bus.overrun); end
        cyc(1, 8'hFF, 0, 0);
        n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL drop_ovr got %b want 1", bus.overrun); end
        n_tests++; if (bus.level !== LW'(DEPTH)) begin n_fail++; $display("FAIL drop_level got %0d want %0d", bus.level, DEPTH); end
    endtask

    task automatic test_ovr_clr();
        cyc(1, 8'hFE, 0, 1); // drop and clear together: set wins
        n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins got %b want 1", bus.overrun); end
        cyc(0, 8'h00, 0, 1);
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", bus.overrun); end
    endtask

    task automatic test_full_simul();
        cyc(1, 8'hEE, 1, 0);
        n_tests++; if (bus.level !== LW'(DEPTH)) begin n_fail++; $display("FAIL simul_level got %0d want %0d", bus.level, DEPTH); end
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL simul_ovr got %b want 0", bus.overrun); end
        n_tests++; if (popped !== 8'h00) begin n_fail++; $display("FAIL simul_popped got %02h want 00", popped); end
        for (int i = 1; i <= DEPTH; i++) begin
            logic [7:0] want;
            want = (i == DEPTH) ? 8'hEE : 8'(i);
            n_tests++;
            if (bus.rd_data !== want) begin n_fail++; $display("FAIL drain_%0d got %02h want %02h", i, bus.rd_data, want); end
            cyc(0, 8'h00, 1, 0);
            if (i == 1) begin
                n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_deassert got %b want 0", bus.full); end
            end
        end
        n_tests++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b want 0", bus.rd_valid); end
    endtask

    task automatic test_wrap();
        int wrote = 0;
        int guard = 0;
        while ((wrote < 40 || q.size() > 0) && guard < 400) begin
            bit ws, rr;
            ws = (wrote < 40) && ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            if (q.size() > 0 && rr) begin
                n_tests++;
                if (bus.rd_data !== q[0]) begin n_fail++; $display("FAIL wrap_data got %02h want %02h", bus.rd_data, q[0]); end
            end
            if (ws && q.size() < DEPTH) wrote++;
            else ws = 1'b0;
            cyc(ws, 8'($urandom), rr, 0);
            guard++;
        end
        n_tests++; if (bus.level !== LW'(0)) begin n_fail++; $display("FAIL wrap_level got %0d want 0", bus.level); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit ws, rr, clr;
            int phase;
            phase = (i / 50) % 3;
            ws  = (phase == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            rr  = (phase == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 15) == 0);
            if (q.size() > 0) begin
                n_tests++;
                if (bus.rd_data !== q[0]) begin n_fail++; $display("FAIL rand_data got %02h want %02h", bus.rd_data, q[0]); end
            end
            cyc(ws, 8'($urandom), rr, clr);
            n_tests++;
            if (bus.level !== LW'(q.size()) || bus.rd_valid !== (q.size() > 0) ||
                bus.full !== (q.size() == DEPTH) || bus.overrun !== m_ovr || bus.timeout !== exp_timeout()) begin
                n_fail++;
                $display("FAIL rand_status got lvl=%0d v=%b f=%b o=%b t=%b want lvl=%0d v=%b f=%b o=%b t=%b",
                         bus.level, bus.rd_valid, bus.full, bus.overrun, bus.timeout,
                         q.size(), q.size() > 0, q.size() == DEPTH, m_ovr, exp_timeout());
            end
        end
        while (q.size() > 0) cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 1);
    endtask

    task automatic test_timeout();
        cyc(1, 8'h5A, 0, 0);
        for (int i = 1; i <= TC + 3; i++) begin
            bit want;
`ifdef UART_RX_FIFO_TIMEOUT_EN
            want = (i >= TC);
`else
            want = 1'b0;
`endif
            cyc(0, 8'h00, 0, 0);
            n_tests++;
            if (bus.timeout !== want) begin n_fail++; $display("FAIL timeout_edge%0d got %b want %b", i, bus.timeout, want); end
        end
        cyc(0, 8'h00, 1, 0);
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b want 0", bus.timeout); end
        for (int i = 0; i < TC + 4; i++) begin
            cyc(0, 8'h00, 0, 0);
            n_tests++;
            if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_empty%0d got %b want 0", i, bus.timeout); end
        end
    endtask

    initial begin
        bus.wr_stb   = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_ready = 1'b0;
        bus.ovr_clr  = 1'b0;
        popped       = 8'h00;
        test_reset();
        test_basic();
        test_fill_overrun();
        test_ovr_clr();
        test_full_simul();
        test_wrap();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
